axis_sym_checker: RTL

//  Streaming scoreboard for the RX path bench and on-chip BIST. Packs SYM_W-bit

---
 rtl/axis_sym_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/axis_sym_checker.sv
// Packs valid-only SYM_W symbols MSB-first into WORD_W words and scores them
// against an AXI-stream reference word stream (counts, first error, overrun).
module axis_sym_checker #(
  parameter int SYM_W       = 2,
  parameter int WORD_W      = 8,
  parameter int CNT_W       = 16,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  input  logic              ref_valid,
  input  logic [WORD_W-1:0] ref_data,
  output logic              ref_ready,
  output logic              word_done,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              first_err_vld,
  output logic              overrun,
  output logic              halted
);

  localparam int N    = WORD_W / SYM_W;
  localparam int SC_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [SC_W-1:0]  SYM_LAST = SC_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  generate
    if ((SYM_W < 1) || (WORD_W % SYM_W != 0)) begin : g_bad_params
      $error("axis_sym_checker: WORD_W must be a non-zero multiple of SYM_W");
    end
  endgenerate

  logic [WORD_W-1:0] sr_reg;
  logic [WORD_W-1:0] sr_next;
  logic [WORD_W-1:0] hold_reg;
  logic [SC_W-1:0]   sym_cnt_reg;
  logic [SC_W-1:0]   sym_cnt_next;
  logic              pending_reg;
  logic [0:0]        state_reg;

  logic sym_fire;
  logic word_complete;
  logic handshake;
  logic mismatch;

  // A single-symbol word has no older bits to shift along.
  generate
    if (N == 1) begin : g_sr_single
      assign sr_next = sym_data;
    end else begin : g_sr_shift
      assign sr_next = {sr_reg[WORD_W-SYM_W-1:0], sym_data};
    end
  endgenerate

  assign sym_cnt_next  = (sym_cnt_reg == SYM_LAST) ? '0 : sym_cnt_reg + 1'b1;
  assign halted        = (state_reg == ST_HALT);
  assign ref_ready     = pending_reg & ~halted;
  assign sym_fire      = sym_valid & ~halted;
  assign word_complete = sym_fire & (sym_cnt_reg == SYM_LAST);
  assign handshake     = ref_valid & ref_ready;
  assign mismatch      = (hold_reg != ref_data);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_reg        <= '0;
      hold_reg      <= '0;
      sym_cnt_reg   <= '0;
      pending_reg   <= 1'b0;
      state_reg     <= ST_RUN;
      word_done     <= 1'b0;
      err_pulse     <= 1'b0;
      err_cnt       <= '0;
      word_cnt      <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      overrun       <= 1'b0;
    end else if (clear) begin
      sr_reg        <= '0;
      hold_reg      <= '0;
      sym_cnt_reg   <= '0;
      pending_reg   <= 1'b0;
      state_reg     <= ST_RUN;
      word_done     <= 1'b0;
      err_pulse     <= 1'b0;
      err_cnt       <= '0;
      word_cnt      <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      word_done <= handshake;
      err_pulse <= handshake & mismatch;

      if (sym_fire) begin
        sr_reg      <= sr_next;
        sym_cnt_reg <= sym_cnt_next;
      end

      // A consumed hold slot on this edge can take the new word with no bubble.
      if (word_complete) begin
        if (!pending_reg || handshake) begin
          hold_reg    <= sr_next;
          pending_reg <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        pending_reg <= 1'b0;
      end

      if (handshake) begin
        if (word_cnt != CNT_MAX) begin
          word_cnt <= word_cnt + 1'b1;
        end
        if (mismatch) begin
          if (err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + 1'b1;
          end
          if (!first_err_vld) begin
            first_err_idx <= word_cnt;
            first_err_vld <= 1'b1;
          end
          if (STOP_ON_ERR) begin
            state_reg <= ST_HALT;
          end
        end
      end
    end
  end

endmodule
